// File: rtl/tc_pl_cap_pkg.sv
// Shared types and constants for the PL capture sequencer.
package tc_pl_cap_pkg;

  // Width of the gain index. Four gain slots are supported.
  localparam int unsigned GAIN_W    = 2;
  localparam int unsigned NUM_GAINS = 1 << GAIN_W;

  // CRC-32 parameters: normal-form polynomial, init and final XOR.
  localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LDDEL,
    ST_LD,
    ST_ACQ,
    ST_GAP,
    ST_DONE
  } cap_state_e;

  // Bit-reverse a 32-bit word; turns the normal polynomial into the
  // form used by the LSB-first (reflected) shift register.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = v[31 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/tc_pl_crc32_dw.sv
// Combinational next-state of a reflected CRC-32 over one DW-bit word,
// consumed least-significant bit first (so byte 0 goes in first).
module tc_pl_crc32_dw
  import tc_pl_cap_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [31:0]   crc_i,
  input  logic [DW-1:0] data_i,
  output logic [31:0]   crc_o
);

  localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

  // Shift every data bit through the register, LSB first.
  always_comb begin
    logic [31:0] c;
    c = crc_i;
    for (int unsigned i = 0; i < DW; i++) begin
      if (c[0] ^ data_i[i]) begin
        c = (c >> 1) ^ POLY_R;
      end else begin
        c = c >> 1;
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/tc_pl_cap_seq.sv
// Capture sequencer: walks gain x phase shots, applies per-gain analog
// settings, fires an LD pulse per shot and streams ADC samples to the
// capture write port. Optional CRC-32 of written samples is built only
// when the macro CAP_CRC32_EN is defined; otherwise cap_crc32 reads 0.
module tc_pl_cap_seq
  import tc_pl_cap_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 32
) (
  input  logic          clk125,
  input  logic          rst,
  input  logic          cap_start,
  input  logic          cap_irq_en,
  input  logic [2:0]    cap_gain_number,
  input  logic [2:0]    cap_phase_number,
  input  logic [31:0]   cap_gain_del,
  input  logic [7:0]    cap_ld_plus,
  input  logic [13:0]   cap_points,
  input  logic [AW-1:0] cap_addr,
  input  logic [17:0]   cap_gain0_cycle,
  input  logic [17:0]   cap_gain1_cycle,
  input  logic [17:0]   cap_gain2_cycle,
  input  logic [17:0]   cap_gain3_cycle,
  input  logic [31:0]   cap_gain0_Lddel,
  input  logic [31:0]   cap_gain1_Lddel,
  input  logic [31:0]   cap_gain2_Lddel,
  input  logic [31:0]   cap_gain3_Lddel,
  input  logic [31:0]   cap_gain0_dacA,
  input  logic [31:0]   cap_gain1_dacA,
  input  logic [31:0]   cap_gain2_dacA,
  input  logic [31:0]   cap_gain3_dacA,
  input  logic [31:0]   cap_gain0_dacB,
  input  logic [31:0]   cap_gain1_dacB,
  input  logic [31:0]   cap_gain2_dacB,
  input  logic [31:0]   cap_gain3_dacB,
  input  logic [5:0]    cap_gain0_lmh,
  input  logic [5:0]    cap_gain1_lmh,
  input  logic [5:0]    cap_gain2_lmh,
  input  logic [5:0]    cap_gain3_lmh,
  input  logic [3:0]    cap_gain0_relay,
  input  logic [3:0]    cap_gain1_relay,
  input  logic [3:0]    cap_gain2_relay,
  input  logic [3:0]    cap_gain3_relay,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_data,
  output logic          cap_cing,
  output logic          ld_out,
  output logic [1:0]    gain_idx,
  output logic [2:0]    phase_idx,
  output logic [31:0]   dacA,
  output logic [31:0]   dacB,
  output logic [5:0]    lmh,
  output logic [3:0]    relay,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [31:0]   cap_crc32,
  output logic [31:0]   cap_time,
  output logic          cap_irq
);

  localparam logic [AW-1:0] ADDR_STEP = AW'(DW / 8);
  localparam logic [18:0]   SC_MAX    = '1;

  // Per-gain configuration tables.
  logic [17:0] cycle_tab [NUM_GAINS];
  logic [31:0] lddel_tab [NUM_GAINS];
  logic [31:0] daca_tab  [NUM_GAINS];
  logic [31:0] dacb_tab  [NUM_GAINS];
  logic [5:0]  lmh_tab   [NUM_GAINS];
  logic [3:0]  relay_tab [NUM_GAINS];

  assign cycle_tab[0] = cap_gain0_cycle;
  assign cycle_tab[1] = cap_gain1_cycle;
  assign cycle_tab[2] = cap_gain2_cycle;
  assign cycle_tab[3] = cap_gain3_cycle;
  assign lddel_tab[0] = cap_gain0_Lddel;
  assign lddel_tab[1] = cap_gain1_Lddel;
  assign lddel_tab[2] = cap_gain2_Lddel;
  assign lddel_tab[3] = cap_gain3_Lddel;
  assign daca_tab[0]  = cap_gain0_dacA;
  assign daca_tab[1]  = cap_gain1_dacA;
  assign daca_tab[2]  = cap_gain2_dacA;
  assign daca_tab[3]  = cap_gain3_dacA;
  assign dacb_tab[0]  = cap_gain0_dacB;
  assign dacb_tab[1]  = cap_gain1_dacB;
  assign dacb_tab[2]  = cap_gain2_dacB;
  assign dacb_tab[3]  = cap_gain3_dacB;
  assign lmh_tab[0]   = cap_gain0_lmh;
  assign lmh_tab[1]   = cap_gain1_lmh;
  assign lmh_tab[2]   = cap_gain2_lmh;
  assign lmh_tab[3]   = cap_gain3_lmh;
  assign relay_tab[0] = cap_gain0_relay;
  assign relay_tab[1] = cap_gain1_relay;
  assign relay_tab[2] = cap_gain2_relay;
  assign relay_tab[3] = cap_gain3_relay;

  // Only two bits of the gain count select a gain slot.
  logic unused_gain_msb;
  assign unused_gain_msb = cap_gain_number[2];

  // Sequencer state.
  cap_state_e       state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;     // SETTLE / LDDEL / LD countdown
  logic [18:0]      sc_q, sc_d;       // shot counter from LD rise, saturating
  logic [13:0]      pts_q, pts_d;     // samples written this shot
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [2:0]       phase_q, phase_d;

  // Registered outputs.
  logic             cap_cing_q, cap_cing_d;
  logic             ld_out_q, ld_out_d;
  logic [31:0]      dacA_q, dacA_d;
  logic [31:0]      dacB_q, dacB_d;
  logic [5:0]       lmh_q, lmh_d;
  logic [3:0]       relay_q, relay_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic [31:0]      cap_time_q, cap_time_d;
  logic             cap_irq_q, cap_irq_d;

  logic             start_acc;
  logic [7:0]       ld_width_m1;

  assign start_acc   = (state_q == ST_IDLE) && cap_start;
  assign ld_width_m1 = (cap_ld_plus == 8'd0) ? 8'd0 : cap_ld_plus - 8'd1;

  // State register and sequencing counters.
  always_ff @(posedge clk125) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sc_q    <= '0;
      pts_q   <= '0;
      gain_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
      pts_q   <= pts_d;
      gain_q  <= gain_d;
      phase_q <= phase_d;
    end
  end

  // Next-state: every countdown state lasts (load value + 1) cycles;
  // each state's countdown is loaded on the transition into it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sc_d    = (sc_q == SC_MAX) ? sc_q : sc_q + 19'd1;
    pts_d   = pts_q;
    gain_d  = gain_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cap_start) begin
          state_d = ST_SETTLE;
          cnt_d   = cap_gain_del;
          gain_d  = '0;
          phase_d = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_LDDEL;
          cnt_d   = lddel_tab[gain_q];
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_LDDEL: begin
        if (cnt_q == '0) begin
          state_d = ST_LD;
          cnt_d   = {24'd0, ld_width_m1};
          sc_d    = '0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_LD: begin
        if (cnt_q == '0) begin
          pts_d   = '0;
          state_d = (cap_points == '0) ? ST_GAP : ST_ACQ;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_ACQ: begin
        if (adc_valid) begin
          pts_d = pts_q + 14'd1;
          if (pts_q + 14'd1 == cap_points) begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (sc_q >= {1'b0, cycle_tab[gain_q]}) begin
          if (phase_q == cap_phase_number) begin
            phase_d = '0;
            if (gain_q == cap_gain_number[GAIN_W-1:0]) begin
              state_d = ST_DONE;
            end else begin
              gain_d  = gain_q + 1'b1;
              state_d = ST_SETTLE;
              cnt_d   = cap_gain_del;
            end
          end else begin
            phase_d = phase_q + 3'd1;
            state_d = ST_LDDEL;
            cnt_d   = lddel_tab[gain_q];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next-values: decoded from the next state so the registered
  // outputs line up with the state they belong to.
  always_comb begin
    cap_cing_d = state_d inside {ST_SETTLE, ST_LDDEL, ST_LD, ST_ACQ, ST_GAP};
    ld_out_d   = (state_d == ST_LD);
    cap_irq_d  = (state_d == ST_DONE) && cap_irq_en;

    dacA_d  = dacA_q;
    dacB_d  = dacB_q;
    lmh_d   = lmh_q;
    relay_d = relay_q;
    if (state_d == ST_SETTLE) begin
      dacA_d  = daca_tab[gain_d];
      dacB_d  = dacb_tab[gain_d];
      lmh_d   = lmh_tab[gain_d];
      relay_d = relay_tab[gain_d];
    end

    wr_en_d   = (state_q == ST_ACQ) && adc_valid;
    wr_data_d = wr_en_d ? adc_data : wr_data_q;
    // wr_addr shows the address of the current write and steps once it
    // has been presented.
    wr_addr_d = wr_en_q ? wr_addr_q + ADDR_STEP : wr_addr_q;

    cap_time_d = (cap_cing_q && (cap_time_q != '1)) ? cap_time_q + 32'd1 : cap_time_q;

    if (start_acc) begin
      wr_addr_d  = cap_addr;
      cap_time_d = '0;
    end
  end

  // Output registers.
  always_ff @(posedge clk125) begin
    if (rst) begin
      cap_cing_q <= 1'b0;
      ld_out_q   <= 1'b0;
      dacA_q     <= '0;
      dacB_q     <= '0;
      lmh_q      <= '0;
      relay_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cap_time_q <= '0;
      cap_irq_q  <= 1'b0;
    end else begin
      cap_cing_q <= cap_cing_d;
      ld_out_q   <= ld_out_d;
      dacA_q     <= dacA_d;
      dacB_q     <= dacB_d;
      lmh_q      <= lmh_d;
      relay_q    <= relay_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cap_time_q <= cap_time_d;
      cap_irq_q  <= cap_irq_d;
    end
  end

`ifdef CAP_CRC32_EN
  logic [31:0] crc_q, crc_d, crc_nxt;
  logic        crc_vld_q, crc_vld_d;

  tc_pl_crc32_dw #(.DW(DW)) u_crc (
    .crc_i  (crc_q),
    .data_i (wr_data_q),
    .crc_o  (crc_nxt)
  );

  // CRC state: re-armed on start, folds in each presented write.
  always_comb begin
    crc_d     = crc_q;
    crc_vld_d = crc_vld_q;
    if (start_acc) begin
      crc_d     = CRC32_INIT;
      crc_vld_d = 1'b0;
    end else if (wr_en_q) begin
      crc_d     = crc_nxt;
      crc_vld_d = 1'b1;
    end
  end

  // CRC registers.
  always_ff @(posedge clk125) begin
    if (rst) begin
      crc_q     <= CRC32_INIT;
      crc_vld_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_vld_q <= crc_vld_d;
    end
  end

  assign cap_crc32 = crc_vld_q ? (crc_q ^ CRC32_XOROUT) : '0;
`else
  assign cap_crc32 = '0;
`endif

  assign cap_cing  = cap_cing_q;
  assign ld_out    = ld_out_q;
  assign gain_idx  = gain_q;
  assign phase_idx = phase_q;
  assign dacA      = dacA_q;
  assign dacB      = dacB_q;
  assign lmh       = lmh_q;
  assign relay     = relay_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cap_time  = cap_time_q;
  assign cap_irq   = cap_irq_q;

endmodule

// File: tb/tb_tc_pl_cap_seq.sv
// Testbench for tc_pl_cap_seq: randomized configurations checked against
// a timeline model of the capture sequence.
module tb_tc_pl_cap_seq;

  localparam int MAXC = 8192;

  logic        clk125 = 1'b0;
  always #4 clk125 = ~clk125;

  logic        rst, cap_start, cap_irq_en;
  logic [2:0]  gn, pn;
  logic [31:0] gdel;
  logic [7:0]  ldp;
  logic [13:0] npts;
  logic [31:0] addr;
  logic [17:0] g_cyc   [4];
  logic [31:0] g_lddel [4];
  logic [31:0] g_daca  [4];
  logic [31:0] g_dacb  [4];
  logic [5:0]  g_lmh   [4];
  logic [3:0]  g_relay [4];
  logic        adc_valid;
  logic [15:0] adc_data;

  logic        cap_cing, ld_out, wr_en, cap_irq;
  logic [1:0]  gain_idx;
  logic [2:0]  phase_idx;
  logic [31:0] dacA, dacB, cap_crc32, cap_time, wr_addr;
  logic [5:0]  lmh;
  logic [3:0]  relay;
  logic [15:0] wr_data;

  tc_pl_cap_seq #(.DW(16), .AW(32)) dut (
    .clk125(clk125), .rst(rst), .cap_start(cap_start), .cap_irq_en(cap_irq_en),
    .cap_gain_number(gn), .cap_phase_number(pn), .cap_gain_del(gdel),
    .cap_ld_plus(ldp), .cap_points(npts), .cap_addr(addr),
    .cap_gain0_cycle(g_cyc[0]), .cap_gain1_cycle(g_cyc[1]),
    .cap_gain2_cycle(g_cyc[2]), .cap_gain3_cycle(g_cyc[3]),
    .cap_gain0_Lddel(g_lddel[0]), .cap_gain1_Lddel(g_lddel[1]),
    .cap_gain2_Lddel(g_lddel[2]), .cap_gain3_Lddel(g_lddel[3]),
    .cap_gain0_dacA(g_daca[0]), .cap_gain1_dacA(g_daca[1]),
    .cap_gain2_dacA(g_daca[2]), .cap_gain3_dacA(g_daca[3]),
    .cap_gain0_dacB(g_dacb[0]), .cap_gain1_dacB(g_dacb[1]),
    .cap_gain2_dacB(g_dacb[2]), .cap_gain3_dacB(g_dacb[3]),
    .cap_gain0_lmh(g_lmh[0]), .cap_gain1_lmh(g_lmh[1]),
    .cap_gain2_lmh(g_lmh[2]), .cap_gain3_lmh(g_lmh[3]),
    .cap_gain0_relay(g_relay[0]), .cap_gain1_relay(g_relay[1]),
    .cap_gain2_relay(g_relay[2]), .cap_gain3_relay(g_relay[3]),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .cap_cing(cap_cing), .ld_out(ld_out), .gain_idx(gain_idx), .phase_idx(phase_idx),
    .dacA(dacA), .dacB(dacB), .lmh(lmh), .relay(relay),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cap_crc32(cap_crc32), .cap_time(cap_time), .cap_irq(cap_irq)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Per-cycle stimulus for one run, indexed by cycle after the start cycle.
  bit          v_arr [MAXC];
  logic [15:0] d_arr [MAXC];

  // Expected and observed event lists.
  int          e_ldk[$], e_ldg[$], e_ldp[$];
  logic [15:0] e_data[$];
  logic [31:0] e_addr[$];
  int          o_ldk[$], o_ldg[$], o_ldp[$], o_relay[$], o_lmh[$];
  logic [31:0] o_daca[$], o_dacb[$];
  logic [15:0] o_data[$];
  logic [31:0] o_addr[$];
  int          o_irqk[$];
  bit          cing_tr [MAXC];
  int          ld_hi;
  int          t_done;
  int          ld_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Software CRC-32 (reflected, 0xEDB88320) over the written words, byte 0 first.
  function automatic logic [31:0] sw_crc();
    logic [31:0] c;
    logic [7:0]  b;
    if (e_data.size() == 0) return 32'd0;
    c = 32'hFFFF_FFFF;
    foreach (e_data[i]) begin
      for (int k = 0; k < 2; k++) begin
        b = (k == 0) ? e_data[i][7:0] : e_data[i][15:8];
        c = c ^ {24'd0, b};
        for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // Timeline model: cycle 0 carries the start request, cycle 1 is the first
  // busy cycle. Each shot: optional settle (gain_del+1), delay (Lddel+1),
  // LD width, acquisition until the sample quota is met, then the shot
  // period measured from LD rise; at least one gap cycle follows ACQ.
  task automatic model_run(input bit seqd);
    int t, seq, nw, cnt;
    e_ldk.delete(); e_ldg.delete(); e_ldp.delete(); e_data.delete(); e_addr.delete();
    ld_w = (ldp == 0) ? 1 : int'(ldp);
    t = 1; seq = 0; nw = 0;
    for (int g = 0; g <= int'(gn[1:0]); g++) begin
      for (int p = 0; p <= int'(pn); p++) begin
        if (p == 0) t += int'(gdel) + 1;
        t += int'(g_lddel[g]) + 1;
        e_ldk.push_back(t); e_ldg.push_back(g); e_ldp.push_back(p);
        cnt = 0;
        for (int a = t + ld_w; cnt < int'(npts) && a < MAXC - 8; a++) begin
          if (v_arr[a]) begin
            seq++;
            if (seqd) d_arr[a] = 16'(seq);
            e_data.push_back(d_arr[a]);
            e_addr.push_back(addr + 32'(nw * 2));
            nw++; cnt++;
          end
          if (cnt == int'(npts)) t = a + 1 - ld_w;
        end
        t = t + ld_w;
        if (t < e_ldk[$] + int'(g_cyc[g])) t = e_ldk[$] + int'(g_cyc[g]);
        t = t + 1;
      end
    end
    t_done = t;
  endtask

  task automatic run_cap(input bit vrand, input bit seqd, input bit busy, input bit do_rst);
    int busy_k, rst_k;
    bit ld_prev;
    for (int k = 0; k < MAXC; k++) begin
      v_arr[k] = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
      d_arr[k] = 16'($urandom);
      cing_tr[k] = 1'b0;
    end
    model_run(seqd);
    busy_k = busy  ? e_ldk[0] + ld_w + 1 : -1;
    rst_k  = do_rst ? e_ldk[0] + 1 : -1;
    o_ldk.delete(); o_ldg.delete(); o_ldp.delete(); o_relay.delete(); o_lmh.delete();
    o_daca.delete(); o_dacb.delete(); o_data.delete(); o_addr.delete(); o_irqk.delete();
    ld_hi = 0; ld_prev = 1'b0;
    @(posedge clk125); #1;
    for (int k = 0; k <= t_done + 3; k++) begin
      cap_start = (k == 0) || (k == busy_k);
      rst       = (k == rst_k);
      adc_valid = v_arr[k];
      adc_data  = d_arr[k];
      cing_tr[k] = cap_cing;
      if (ld_out) begin
        ld_hi++;
        if (!ld_prev) begin
          o_ldk.push_back(k); o_ldg.push_back(int'(gain_idx)); o_ldp.push_back(int'(phase_idx));
          o_relay.push_back(int'(relay)); o_lmh.push_back(int'(lmh));
          o_daca.push_back(dacA); o_dacb.push_back(dacB);
        end
      end
      ld_prev = ld_out;
      if (wr_en) begin o_data.push_back(wr_data); o_addr.push_back(wr_addr); end
      if (cap_irq) o_irqk.push_back(k);
      if (do_rst && k == rst_k + 1) begin
        chk("rst_ld_out", ld_out, 0);
        chk("rst_cing", cap_cing, 0);
        chk("rst_time", cap_time, 0);
        chk("rst_gain_phase", {gain_idx, phase_idx}, 0);
        chk("rst_settings", {dacA, dacB, lmh, relay}, 0);
        chk("rst_wr", {wr_en, wr_addr, wr_data}, 0);
        chk("rst_crc_irq", {cap_crc32, cap_irq}, 0);
        break;
      end
      @(posedge clk125); #1;
    end
    cap_start = 1'b0; rst = 1'b0; adc_valid = 1'b0;
    if (do_rst) begin
      repeat (4) @(posedge clk125);
      #1;
      chk("rst_stays_idle", {cap_cing, cap_irq, ld_out}, 0);
      return;
    end
    chk("cing_start", {cing_tr[0], cing_tr[1]}, 2'b01);
    chk("cing_end", {cing_tr[t_done - 1], cing_tr[t_done]}, 2'b10);
    chk("ld_count", o_ldk.size(), e_ldk.size());
    chk("ld_width_total", ld_hi, e_ldk.size() * ld_w);
    for (int i = 0; i < e_ldk.size() && i < o_ldk.size(); i++) begin
      chk("ld_rise_cycle", o_ldk[i], e_ldk[i]);
      chk("ld_gain_phase", {o_ldg[i], o_ldp[i]}, {e_ldg[i], e_ldp[i]});
      chk("relay_lmh", {o_relay[i], o_lmh[i]}, {32'(g_relay[e_ldg[i]]), 32'(g_lmh[e_ldg[i]])});
      chk("dacA_dacB", {o_daca[i], o_dacb[i]}, {g_daca[e_ldg[i]], g_dacb[e_ldg[i]]});
    end
    chk("wr_count", o_data.size(), e_data.size());
    for (int i = 0; i < e_data.size() && i < o_data.size(); i++) begin
      chk("wr_data", o_data[i], e_data[i]);
      chk("wr_addr", o_addr[i], e_addr[i]);
    end
    if (cap_irq_en) begin
      chk("irq_count", o_irqk.size(), 1);
      if (o_irqk.size() > 0) chk("irq_cycle", o_irqk[0], t_done);
    end else begin
      chk("irq_none", o_irqk.size(), 0);
    end
    chk("cap_time", cap_time, 32'(t_done - 1));
`ifdef CAP_CRC32_EN
    chk("cap_crc32", cap_crc32, sw_crc());
`else
    chk("cap_crc32_off", cap_crc32, 0);
`endif
  endtask

  task automatic rand_cfg(input int max_cyc, input int max_pts);
    gdel = 32'($urandom_range(0, 12));
    ldp  = 8'($urandom_range(0, 6));
    npts = 14'($urandom_range(0, max_pts));
    addr = $urandom;
    cap_irq_en = 1'b1;
    for (int g = 0; g < 4; g++) begin
      g_cyc[g]   = 18'($urandom_range(0, max_cyc));
      g_lddel[g] = 32'($urandom_range(0, 10));
      g_daca[g]  = $urandom;
      g_dacb[g]  = $urandom;
      g_lmh[g]   = 6'($urandom);
      g_relay[g] = 4'(g + 4 * $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b1; cap_start = 1'b0; adc_valid = 1'b0; adc_data = '0;
    rand_cfg(50, 10);
    gn = '0; pn = '0;
    repeat (3) @(posedge clk125);
    #1;
    chk("reset_ctrl", {cap_cing, ld_out, wr_en, cap_irq}, 0);
    chk("reset_idx_set", {gain_idx, phase_idx, dacA, dacB, lmh, relay}, 0);
    chk("reset_wr_crc_time", {wr_addr, wr_data, cap_crc32 ^ cap_time}, 0);
    rst = 1'b0;

    // Basic run.
    gn = 3'd0; pn = 3'd0; gdel = 32'd10; ldp = 8'd4; npts = 14'd8; addr = 32'h0000_1000;
    cap_irq_en = 1'b1;
    for (int g = 0; g < 4; g++) begin g_lddel[g] = 32'd5; g_cyc[g] = 18'd100; end
    run_cap(1'b0, 1'b0, 1'b0, 1'b0);
    chk("basic_time_118", cap_time, 32'd118);
    chk("basic_ld_width", ld_hi, 4);
    chk("basic_first_last_addr", {o_addr[0], o_addr[$]}, {32'h1000, 32'h100E});

    // Full sweep, random sample valid.
    rand_cfg(120, 12);
    gn = 3'd3; pn = 3'd2;
    run_cap(1'b1, 1'b0, 1'b0, 1'b0);
    chk("sweep_12_pulses", o_ldk.size(), 12);

    // Second start mid-ACQ ignored, interrupt disabled.
    rand_cfg(80, 10);
    gn = 3'd1; pn = 3'd1; npts = 14'd6; cap_irq_en = 1'b0;
    run_cap(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during LD, then a normal run.
    rand_cfg(60, 8);
    gn = 3'd1; pn = 3'd0; ldp = 8'd5;
    run_cap(1'b0, 1'b0, 1'b0, 1'b1);
    run_cap(1'b1, 1'b0, 1'b0, 1'b0);

    // All-zero timing edge cases.
    rand_cfg(10, 4);
    gn = 3'd2; pn = 3'd1; npts = '0; gdel = '0; ldp = '0;
    for (int g = 0; g < 4; g++) begin g_cyc[g] = '0; g_lddel[g] = '0; end
    run_cap(1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero_no_writes", o_data.size(), 0);
    chk("zero_ld_1clk", ld_hi, 6);

    // Sequential samples 1..8 for the CRC, across an address wrap.
    rand_cfg(40, 8);
    gn = 3'd0; pn = 3'd0; npts = 14'd8; addr = 32'hFFFF_FFFA;
    run_cap(1'b1, 1'b1, 1'b0, 1'b0);

    // Random configurations, gain count bit 2 set to show it is ignored.
    for (int r = 0; r < 3; r++) begin
      rand_cfg(150, 16);
      gn = 3'(4 + $urandom_range(0, 3));
      pn = 3'($urandom_range(0, 3));
      run_cap(1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tc_pl_cap_seq.md
# tc_pl_cap_seq

Capture sequencer on the 125 MHz PL fabric. It consumes the latched capture configuration (`cap_*` fields) and walks gain × phase shots. For each shot it applies analog settings, fires an LD pulse, and streams ADC samples to the capture write port. It returns `cap_cing`, `cap_crc32` and `cap_time`, closing the loop with the GP0 configuration latch.

## Interface
Parameters:
- DW, 16, ADC sample width (even, ≤32)
- AW, 32, write address width

Ports (one clock; reset is synchronous and active-high):
- clk125  in  1  system clock
- rst  in  1  synchronous active-high reset
- cap_start  in  1  single-cycle start request from PS
- cap_irq_en  in  1  enable completion interrupt
- cap_gain_number  in  3  number of gains minus 1 (0..3 used, bit 2 ignored)
- cap_phase_number  in  3  number of phases minus 1
- cap_gain_del  in  32  settle clocks after gain change
- cap_ld_plus  in  8  LD pulse width, clocks (0 treated as 1)
- cap_points  in  14  samples per shot
- cap_addr  in  AW  first write address
- cap_gainN_cycle (N=0..3)  in  18 each  minimum shot period, clocks from LD rise
- cap_gainN_Lddel (N=0..3)  in  32 each  clocks from shot start to LD rise
- cap_gainN_dacA/dacB/lmh/relay (N=0..3)  in  32/32/6/4  per-gain analog settings
- adc_valid, adc_data  in  1, DW  sample stream
- cap_cing  out  1  capture in progress
- ld_out  out  1  laser drive pulse
- gain_idx, phase_idx  out  2, 3  current gain and phase
- dacA, dacB, lmh, relay  out  32, 32, 6, 4  muxed settings of the current gain
- wr_en, wr_addr, wr_data  out  1, AW, DW  sample write port
- cap_crc32  out  32  CRC of all written samples
- cap_time  out  32  clocks spent with cap_cing high
- cap_irq  out  1  completion pulse

## Operation
- States: IDLE → SETTLE → LDDEL → LD → ACQ → GAP → (next phase: LDDEL | next gain: SETTLE | DONE) → IDLE.
- IDLE:
  - `cap_start` loads counters.
  - `gain_idx` and `phase_idx` are set to 0.
  - `wr_addr` is set to `cap_addr`.
  - `cap_time` and the CRC are cleared.
  - Next state is SETTLE.
- SETTLE: outputs select gain `gain_idx`. Wait `cap_gain_del` clocks; 0 means advance the next cycle.
- LDDEL: wait `cap_gainN_Lddel` clocks.
- LD: `ld_out` is high for `max(cap_ld_plus,1)` clocks.
- ACQ:
  - Each `adc_valid` produces a `wr_en` pulse with `wr_data=adc_data`.
  - `wr_addr` advances by DW/8 after each write.
  - Leave after `cap_points` writes. `cap_points=0` skips ACQ.
- GAP: a shot counter runs from LD rise. Wait until it reaches `cap_gainN_cycle`; if already reached, advance immediately.
- Sequencing:
  - `phase_idx` increments until it equals `cap_phase_number`, then resets to 0.
  - On that wrap, `gain_idx` increments until it equals `cap_gain_number[1:0]`, then DONE.
- DONE: one cycle. `cap_irq` = `cap_irq_en`. Then IDLE.
- `cap_start` outside IDLE is ignored.
- `wr_addr` wraps modulo 2^AW.
- `cap_time` saturates at 0xFFFFFFFF.

## Timing
- Reset values:
  - `cap_cing`, `ld_out`, `wr_en`, `cap_irq` = 0.
  - `gain_idx`, `phase_idx`, settings = 0.
  - `wr_addr` = 0, `wr_data` = 0.
  - `cap_crc32` = 0, `cap_time` = 0.
- Reset mid-capture: next cycle is IDLE with all reset values. No DONE, no irq.
- `cap_cing` rises the cycle after the accepted `cap_start`. It falls in the cycle DONE is entered. `cap_cing` low means the config latch may reload.
- `cap_time` increments every clock `cap_cing` is high. It holds after DONE and clears only on the next accepted start.
- Settings outputs are registered and change in the first SETTLE cycle.
- `ld_out` rises the cycle after LDDEL expires.
- `wr_*` lag `adc_valid` by 1 clock.
- The CRC updates the cycle after each `wr_en`. `cap_crc32` is final and stable from the DONE cycle.
- `adc_valid` outside ACQ is dropped.

## Configuration
- `CAP_CRC32_EN` defined:
  - CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected, final XOR 0xFFFFFFFF) over each `wr_data`, least-significant byte first.
  - `cap_crc32` reads 0 until the CRC state is updated.
- `CAP_CRC32_EN` undefined: `cap_crc32` is tied to 0 and no CRC logic is built.

## Structure
- Package `tc_pl_cap_pkg`: state enum, `CRC32_POLY`, `CRC32_INIT`, `CRC32_XOROUT`, and the gain-count width constant.
- Sub-module `tc_pl_crc32_dw`: combinational next-CRC for a DW-bit word. Instantiated only under `CAP_CRC32_EN`.

## Test plan
- Basic run:
  - Stimulus: gain_number=0, phase_number=0, gain_del=10, Lddel=5, ld_plus=4, points=8, cycle=100, `adc_valid` always high.
  - Response: 8 writes at `cap_addr` +0,2,…,14; `ld_out` high for 4 clocks; `cap_time`=118; one `cap_irq`.
- Full sweep:
  - Stimulus: gain_number=3, phase_number=2.
  - Response: 12 LD pulses. `gain_idx`/`phase_idx` sequence (0,0)(0,1)(0,2)(1,0)…(3,2). `relay` follows `cap_gainN_relay`.
- Start while busy:
  - Stimulus: second `cap_start` mid-ACQ.
  - Response: ignored, run unchanged. With `cap_irq_en`=0, no `cap_irq`.
- Reset mid-capture:
  - Stimulus: `rst` in LD.
  - Response: next cycle `ld_out`=0 and `cap_cing`=0; a new start runs normally.
- CRC check:
  - Stimulus: `CAP_CRC32_EN` defined, DW=16, samples 0x0001..0x0008.
  - Response: `cap_crc32` equals the software CRC-32 of bytes 01 00 02 00 … 08 00.
- Zero edge cases:
  - Stimulus: points=0, gain_del=0, ld_plus=0, cycle=0.
  - Response: no writes, 1-clock LD, completes without hang.
